// File: rtl/serial_add_pkg.sv
// Shared types for the serial adder sequencing controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CARRY = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit-counter width; a 1-bit operand still gets a 1-bit counter.
    function automatic int cw_of(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl.sv
// Feeds W-bit operand pairs LSB-first to an external 1-bit carry-state adder
// cell, collects the sum bits and final carry, and hands back the result.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic         add_in1,
    output logic         add_in2,
    output logic         add_rstn,
    input  logic         add_s,
    input  logic         add_c
);

    localparam int CW = cw_of(W);

    state_t        state, state_nxt;
    logic [W-1:0]  a_sh, b_sh, sum_sh;
    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        sum_sh <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so the LSB lands at bit 0 after W shifts.
                    sum_sh <= (sum_sh >> 1) | (W'(add_s) << (W - 1));
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (!last) cnt <= cnt + 1'b1;
                end
                CARRY: begin
                    cout <= add_c;
                    sum  <= sum_sh;
                end
                DONE: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: if (last) state_nxt = CARRY;
            CARRY: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
        endcase
    end

    // The cell carry only runs during SHIFT; it is held clear everywhere else,
    // including CARRY, where it clears on the same edge that samples it.
    assign add_rstn = rstn && (state == SHIFT);
    assign add_in1  = (state == SHIFT) ? a_sh[0] : 1'b0;
    assign add_in2  = (state == SHIFT) ? b_sh[0] : 1'b0;
    assign busy     = (state != IDLE);

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencing controller for an external 1-bit carry-state serial adder cell.
- Accepts W-bit operand pairs over a valid/ready handshake and feeds them to the cell LSB-first, one bit per clock.
- Collects the sum bits and captures the final carry.
- Returns the W-bit sum and carry-out over a second valid/ready handshake.
- Owns the cell's carry-register reset so that no carry leaks between operations.

Parameters:
- W, 8, operand/sum width in bits (legal W >= 1)
- CW, $clog2(W>1?W:2), bit-counter width (derived, not overridable)

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept operands
- a  in  W  operand A
- b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  W  result sum
- cout  out  1  result carry-out
- busy  out  1  high when state != IDLE
- add_in1  out  1  bit to cell input 1
- add_in2  out  1  bit to cell input 2
- add_rstn  out  1  cell carry-register reset (sync, active-low)
- add_s  in  1  cell sum bit (combinational from current carry and inputs)
- add_c  in  1  cell registered carry state

Behaviour:
- Reset: clk is the clock; rstn is the reset, synchronous and active-low. Reset forces state=IDLE, shift regs=0, cnt=0, sum=0, cout=0, out_valid=0.
- Reset mid-operation (any state) abandons the operation. The pending result is lost and no out_valid pulse follows.
- add_rstn = rstn AND (state==SHIFT), combinational. The cell carry is held at 0 in every other state.
- add_in1/add_in2 = a_sh[0]/b_sh[0] in SHIFT, 0 otherwise.
- States: IDLE, SHIFT, CARRY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, at the edge: a_sh<=a, b_sh<=b, cnt<=0, sum_sh<=0, go SHIFT.
- SHIFT (W cycles):
  - Each edge: sum_sh <= {add_s, sum_sh[W-1:1]}; a_sh, b_sh shift right one with zero fill; cnt<=cnt+1.
  - When cnt==W-1, go CARRY (cnt not incremented past W-1).
- CARRY (1 cycle):
  - add_c holds the final carry.
  - At the edge: cout<=add_c, sum<=sum_sh, go DONE.
  - add_rstn is already low, so the cell clears at the same edge, after the sample.
- DONE:
  - out_valid=1. sum/cout are stable until the handshake.
  - On out_valid & out_ready: go IDLE.
  - out_ready low holds DONE indefinitely.
- in_ready=0 in SHIFT, CARRY and DONE. in_valid is ignored there; the upstream holds a/b until accepted.
- Latency: the accept edge is edge 0. out_valid rises after edge W+1, so the first observable cycle is W+1 cycles after acceptance.
- Throughput: one result per W+3 cycles with out_ready tied high (accept edge, W SHIFT, CARRY, DONE, the IDLE acceptance cycle).
- W=1: SHIFT lasts exactly one cycle.
- Arithmetic: sum = (a+b) mod 2^W; cout = bit W of a+b. The controller performs no arithmetic of its own.

Decomposition:
- Shared package serial_add_pkg contains:
  - state enum: IDLE=2'd0, SHIFT=2'd1, CARRY=2'd2, DONE=2'd3
  - localparam helper for CW
- No sub-module is needed; the shift registers and counter live inline.
- The bench instantiates the existing 1-bit carry-state adder cell against the add_* ports. The testbench top wires the two together; the controller does not instantiate the cell.

Test Plan:
- W=8, a=0x5A, b=0x3C, out_ready=1 -> sum=0x96, cout=0, out_valid rises 9 cycles after accept, pulses for 1 cycle.
- a=0xFF, b=0x01 -> sum=0x00, cout=1. add_rstn low on every cycle outside the 8 SHIFT cycles.
- Back-to-back: a=0xFF, b=0xFF (sum=0xFE, cout=1), then a=0x00, b=0x00 -> sum=0x00, cout=0. Proves the carry is cleared between operations.
- Backpressure: a=0x81, b=0x81, out_ready=0 for 5 cycles in DONE -> out_valid, sum=0x02, cout=1 held stable. in_ready=0 throughout. A new in_valid is not accepted until after the handshake.
- Reset mid-SHIFT: rstn low for 1 cycle at SHIFT cnt=3 -> state IDLE, out_valid never asserts, sum=0, cout=0. The next operation a=0x10, b=0x20 gives sum=0x30, cout=0.
- W=1 build: a=1, b=1 -> sum=0, cout=1, out_valid 2 cycles after accept.
